// File: rtl/usb_token_decoder.sv
// USB token decoder: parses PID, token and SOF packets from a byte-wide receive stream.
// It checks the PID, packet length, CRC5, address and endpoint, and reports each result as a one-cycle pulse.
module usb_token_decoder #(
    parameter int NUM_ENDP   = 4,
    parameter int CHECK_ADDR = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic [6:0]  dev_addr,
    output logic        token_valid,
    output logic [3:0]  token_pid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_endp,
    output logic        sof_valid,
    output logic [10:0] frame_num,
    output logic        pid_valid,
    output logic [3:0]  pid_out,
    output logic        pid_err,
    output logic        crc5_err,
    output logic        len_err,
    output logic        endp_err
);
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001, PID_IN    = 4'b1001, PID_SOF   = 4'b0101, PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011, PID_DATA2 = 4'b0111, PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010, PID_NAK   = 4'b1010, PID_STALL = 4'b1110, PID_NYET  = 4'b0110,
        PID_PRE   = 4'b1100, PID_SPLIT = 4'b1000, PID_PING  = 4'b0100
    } pid_t;

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOK1, S_TOK2, S_WAIT_EOP, S_DISCARD
    } state_t;

    localparam logic [4:0] ENDP_LIMIT = 5'(NUM_ENDP);

    state_t     state, state_next;
    logic       prev_idle;
    logic [3:0] pid_q;
    logic [7:0] byte1_q, byte2_q;
    logic       len_pend, len_pend_d;
    logic       tok_d, sof_d, pidv_d, piderr_d, crc_d, len_d, endp_d;

    logic       rise, byte_in, eop, pid_ok, is_tok, crc_ok, addr_ok;
    logic [3:0] endp;

    // Feeding the transmitted (inverted) CRC back through the register leaves a fixed residual.
    function automatic logic crc5_good(input logic [15:0] bits);
        logic [4:0] r;
        logic       fb;
        r = 5'h1f;
        for (int i = 0; i < 16; i++) begin
            fb = bits[i] ^ r[4];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return r == 5'b01100;
    endfunction

    // prev_idle resets to 0, so a line that is already busy when reset is released does not count as a rising edge.
    assign rise    = rx_active & prev_idle;
    assign byte_in = rx_active & rx_valid;
    assign eop     = ~rx_active;
    assign pid_ok  = (rx_data[7:4] == ~rx_data[3:0]);
    assign is_tok  = (rx_data[3:0] == PID_OUT) || (rx_data[3:0] == PID_IN) ||
                     (rx_data[3:0] == PID_SOF) || (rx_data[3:0] == PID_SETUP);
    assign crc_ok  = crc5_good({byte2_q, byte1_q});
    assign addr_ok = (CHECK_ADDR == 0) || (byte1_q[6:0] == dev_addr);
    assign endp    = {byte2_q[2:0], byte1_q[7]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rise) begin
            state_next = S_PID;
        end else begin
            case (state)
                S_PID: begin
                    if (eop)          state_next = S_IDLE;
                    else if (byte_in) state_next = (pid_ok && is_tok) ? S_TOK1 : S_DISCARD;
                end
                S_TOK1: begin
                    if (eop)          state_next = S_IDLE;
                    else if (byte_in) state_next = S_TOK2;
                end
                S_TOK2: begin
                    if (eop)          state_next = S_IDLE;
                    else if (byte_in) state_next = S_WAIT_EOP;
                end
                S_WAIT_EOP: begin
                    if (eop)          state_next = S_IDLE;
                    else if (byte_in) state_next = S_DISCARD;
                end
                S_DISCARD: begin
                    if (eop)          state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tok_d      = 1'b0;
        sof_d      = 1'b0;
        pidv_d     = 1'b0;
        piderr_d   = 1'b0;
        crc_d      = 1'b0;
        len_d      = 1'b0;
        endp_d     = 1'b0;
        len_pend_d = len_pend;
        if (rise) begin
            len_pend_d = 1'b0;
        end else begin
            case (state)
                S_PID: begin
                    if (byte_in && !pid_ok)      piderr_d = 1'b1;
                    else if (byte_in && !is_tok) pidv_d   = 1'b1;
                end
                S_TOK1, S_TOK2: begin
                    if (eop) len_d = 1'b1;
                end
                S_WAIT_EOP: begin
                    if (eop) begin
                        if (!crc_ok)                    crc_d  = 1'b1;
                        else if (pid_q == PID_SOF)      sof_d  = 1'b1;
                        else if (!addr_ok)              ;
                        else if ({1'b0, endp} >= ENDP_LIMIT) endp_d = 1'b1;
                        else                            tok_d  = 1'b1;
                    end else if (byte_in) begin
                        len_pend_d = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (eop) begin
                        len_d      = len_pend;
                        len_pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_idle   <= 1'b0;
            len_pend    <= 1'b0;
            pid_q       <= '0;
            byte1_q     <= '0;
            byte2_q     <= '0;
            token_valid <= 1'b0;
            sof_valid   <= 1'b0;
            pid_valid   <= 1'b0;
            pid_err     <= 1'b0;
            crc5_err    <= 1'b0;
            len_err     <= 1'b0;
            endp_err    <= 1'b0;
            token_pid   <= '0;
            token_addr  <= '0;
            token_endp  <= '0;
            frame_num   <= '0;
            pid_out     <= '0;
        end else begin
            prev_idle   <= ~rx_active;
            len_pend    <= len_pend_d;
            token_valid <= tok_d;
            sof_valid   <= sof_d;
            pid_valid   <= pidv_d;
            pid_err     <= piderr_d;
            crc5_err    <= crc_d;
            len_err     <= len_d;
            endp_err    <= endp_d;
            if (state == S_PID  && byte_in) pid_q   <= rx_data[3:0];
            if (state == S_TOK1 && byte_in) byte1_q <= rx_data;
            if (state == S_TOK2 && byte_in) byte2_q <= rx_data;
            if (tok_d) begin
                token_pid  <= pid_q;
                token_addr <= byte1_q[6:0];
                token_endp <= endp;
            end
            if (sof_d)  frame_num <= {byte2_q[2:0], byte1_q};
            if (pidv_d) pid_out   <= rx_data[3:0];
        end
    end
endmodule

// File: tb/tb_usb_token_decoder.sv
// Bench for usb_token_decoder: a fixed table of packets, a reset-during-packet sequence and random packets.
// Every packet is checked against a reference model of the decoder.
module tb_usb_token_decoder;
    localparam int NUM_ENDP = 4;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, rx_active = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic        token_valid, sof_valid, pid_valid, pid_err, crc5_err, len_err, endp_err;
    logic [3:0]  token_pid, token_endp, pid_out;
    logic [6:0]  token_addr;
    logic [10:0] frame_num;

    always #5 clk = ~clk;

    usb_token_decoder #(.NUM_ENDP(NUM_ENDP), .CHECK_ADDR(1)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .dev_addr(dev_addr), .token_valid(token_valid),
        .token_pid(token_pid), .token_addr(token_addr), .token_endp(token_endp),
        .sof_valid(sof_valid), .frame_num(frame_num), .pid_valid(pid_valid),
        .pid_out(pid_out), .pid_err(pid_err), .crc5_err(crc5_err), .len_err(len_err),
        .endp_err(endp_err)
    );

    localparam logic [6:0] K_NONE = 7'b0000000, K_TOK = 7'b1000000, K_SOF = 7'b0100000,
                           K_PIDV = 7'b0010000, K_PERR = 7'b0001000, K_CRC = 7'b0000100,
                           K_LEN  = 7'b0000010, K_ENDP = 7'b0000001;

    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  n;
        logic [6:0]  da;
        logic [6:0]  k;
    } vec_t;

    logic [6:0] pv;
    assign pv = {token_valid, sof_valid, pid_valid, pid_err, crc5_err, len_err, endp_err};

    int vectors = 0, errors = 0, cyc = 0;
    int ev_n, ev_cyc;
    logic [6:0] ev_kind;
    logic [3:0] ev_pid;
    logic [3:0] m_tpid = '0, m_tendp = '0;
    logic [6:0] m_taddr = '0;
    logic [10:0] m_frame = '0;
    vec_t tbl[16];

    // CRC field as transmitted: register preset to ones, data fed LSB first, then inverted; field bit 0 goes on the wire first.
    function automatic logic [4:0] crc5_field(input logic [10:0] d);
        int r, top;
        logic [4:0] f;
        r = 31;
        for (int i = 0; i < 11; i++) begin
            top = (r >> 4) & 1;
            r = (r << 1) & 31;
            if (int'(d[i]) != top) r = r ^ 5;
        end
        for (int i = 0; i < 5; i++) f[i] = ((r >> (4 - i)) & 1) == 0;
        return f;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] pid, input logic [10:0] fld, input logic [4:0] flip);
        logic [7:0] b2;
        b2 = {crc5_field(fld) ^ flip, fld[10:8]};
        return {8'h00, b2, fld[7:0], ~pid, pid};
    endfunction

    task automatic step(input logic act, input logic vld, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        if (pv != 7'b0) begin
            if (ev_n == 0) begin ev_kind = pv; ev_cyc = cyc; ev_pid = pid_out; end
            ev_n++;
        end
        rx_active = act; rx_valid = vld; rx_data = d;
    endtask

    task automatic send(input logic [31:0] bytes, input int n, input logic [6:0] da,
                        input bit gaps, output int c0, output int ce);
        dev_addr = da;
        ev_n = 0; ev_kind = K_NONE; ev_cyc = -1; ev_pid = '0; c0 = -1;
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) step(1'b1, 1'b0, 8'($urandom));
            step(1'b1, 1'b1, bytes[8*i +: 8]);
            if (i == 0) c0 = cyc;
        end
        step(1'b0, 1'b0, 8'h00);
        ce = cyc;
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    // Reference model applied to the whole packet; the expected kind comes from the table or from the model.
    task automatic check_pkt(input logic [31:0] bytes, input int n, input logic [6:0] da, input int c0,
                             input int ce, input bit use_tk, input logic [6:0] tk, input int id);
        logic [3:0] pid;
        logic [10:0] fld;
        logic [6:0] k, want;
        int kc;
        k = K_NONE; kc = -1; pid = bytes[3:0];
        if (n > 0) begin
            if (bytes[7:4] != ~pid) begin k = K_PERR; kc = c0 + 1; end
            else if (!(pid inside {4'h1, 4'h9, 4'h5, 4'hD})) begin k = K_PIDV; kc = c0 + 1; end
            else if (n != 3) begin k = K_LEN; kc = ce + 1; end
            else begin
                fld = {bytes[18:16], bytes[15:8]};
                kc = ce + 1;
                if (bytes[23:19] != crc5_field(fld)) k = K_CRC;
                else if (pid == 4'h5) begin k = K_SOF; m_frame = fld; end
                else if (fld[6:0] != da) kc = -1;
                else if (int'(fld[10:7]) >= NUM_ENDP) k = K_ENDP;
                else begin k = K_TOK; m_tpid = pid; m_taddr = fld[6:0]; m_tendp = fld[10:7]; end
            end
        end
        want = use_tk ? tk : k;
        vectors++;
        if (ev_kind !== want || ev_n != int'(want != K_NONE) || (want != K_NONE && ev_cyc != kc)) begin
            errors++;
            $display("FAIL pulse[%0d]: got kind=%b count=%0d cycle=%0d, want kind=%b count=%0d cycle=%0d",
                     id, ev_kind, ev_n, ev_cyc, want, int'(want != K_NONE), kc);
        end
        vectors++;
        if ({token_pid, token_addr, token_endp, frame_num} !== {m_tpid, m_taddr, m_tendp, m_frame}) begin
            errors++;
            $display("FAIL fields[%0d]: got pid=%h addr=%h endp=%h frame=%h, want pid=%h addr=%h endp=%h frame=%h",
                     id, token_pid, token_addr, token_endp, frame_num, m_tpid, m_taddr, m_tendp, m_frame);
        end
        if (want == K_PIDV) begin
            vectors++;
            if (ev_pid !== pid) begin
                errors++;
                $display("FAIL pid_out[%0d]: got %b want %b", id, ev_pid, pid);
            end
        end
    endtask

    task automatic check_zero(input string what);
        vectors++;
        if ({pv, token_pid, token_addr, token_endp, frame_num, pid_out} !== '0) begin
            errors++;
            $display("FAIL %s: got pulses=%b pid=%h addr=%h endp=%h frame=%h pid_out=%h, want all 0",
                     what, pv, token_pid, token_addr, token_endp, frame_num, pid_out);
        end
    endtask

    initial begin
        int c0, ce, n;
        logic [31:0] bytes;
        logic [6:0] da;
        logic [10:0] fld;

        tbl[0]  = '{mk(4'h9, {4'd1, 7'h05}, 5'd0),  3'd3, 7'h05, K_TOK};
        tbl[1]  = '{mk(4'h9, {4'd1, 7'h05}, 5'd4),  3'd3, 7'h05, K_CRC};
        tbl[2]  = '{32'h0012346A,                   3'd3, 7'h05, K_PERR};
        tbl[3]  = '{mk(4'h5, 11'h7FF, 5'd0),        3'd3, 7'h05, K_SOF};
        tbl[4]  = '{mk(4'h1, {4'd5, 7'h05}, 5'd0),  3'd3, 7'h05, K_ENDP};
        tbl[5]  = '{mk(4'h1, {4'd2, 7'h05}, 5'd0),  3'd2, 7'h05, K_LEN};
        tbl[6]  = '{mk(4'h1, {4'd2, 7'h06}, 5'd0),  3'd3, 7'h05, K_NONE};
        tbl[7]  = '{mk(4'hD, {4'd0, 7'h05}, 5'd0),  3'd3, 7'h05, K_TOK};
        tbl[8]  = '{32'h000000D2,                   3'd1, 7'h05, K_PIDV};
        tbl[9]  = '{32'h000055C3,                   3'd3, 7'h05, K_PIDV};
        tbl[10] = '{mk(4'h1, {4'd2, 7'h05}, 5'd0) | 32'hAA000000, 3'd4, 7'h05, K_LEN};
        tbl[11] = '{mk(4'h9, {4'd3, 7'h05}, 5'd0),  3'd3, 7'h05, K_TOK};
        tbl[12] = '{mk(4'h9, {4'd4, 7'h05}, 5'd0),  3'd3, 7'h05, K_ENDP};
        tbl[13] = '{mk(4'h1, {4'd1, 7'h05}, 5'd0),  3'd1, 7'h05, K_LEN};
        tbl[14] = '{32'h00000000,                   3'd0, 7'h05, K_NONE};
        tbl[15] = '{mk(4'h5, 11'h000, 5'd1),        3'd3, 7'h2A, K_CRC};

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            send(tbl[i].bytes, int'(tbl[i].n), tbl[i].da, 1'b0, c0, ce);
            check_pkt(tbl[i].bytes, int'(tbl[i].n), tbl[i].da, c0, ce, 1'b1, tbl[i].k, i);
        end

        // Reset arrives after byte1 of an OUT token and is released while the line is still busy.
        ev_n = 0; ev_kind = K_NONE; ev_cyc = -1;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hE1);
        step(1'b1, 1'b1, 8'h85);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk) reset_n = 1'b1;
        m_tpid = '0; m_taddr = '0; m_tendp = '0; m_frame = '0;
        step(1'b1, 1'b1, mk(4'h1, {4'd1, 7'h05}, 5'd0)[23:16]);
        step(1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        vectors++;
        if (ev_n != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d pulses (first %b), want 0", ev_n, ev_kind);
        end
        send(32'h000000D2, 1, 7'h05, 1'b0, c0, ce);
        check_pkt(32'h000000D2, 1, 7'h05, c0, ce, 1'b1, K_PIDV, 100);

        for (int i = 0; i < 60; i++) begin
            da = 7'($urandom);
            fld = 11'($urandom);
            if ($urandom_range(0, 1) == 0) fld[6:0] = da;
            case ($urandom_range(0, 4))
                0: bytes = mk(4'h1, fld, 5'd0);
                1: bytes = mk(4'h9, fld, 5'd0);
                2: bytes = mk(4'h5, fld, 5'd0);
                3: bytes = mk(4'hD, fld, 5'd0);
                default: bytes = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) bytes[23:19] = bytes[23:19] ^ 5'($urandom_range(1, 31));
            bytes[31:24] = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 3;
            send(bytes, n, da, 1'b1, c0, ce);
            check_pkt(bytes, n, da, c0, ce, 1'b0, K_NONE, 200 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
